// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight, and hands words to decode.
// Optional misaligned-fetch fault path is compiled in when FETCH_MISALIGN_EN is defined.
module pc_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              inst_valid_reg, inst_valid_next;
    logic [DATA_W-1:0] inst_data_reg, inst_data_next;
    logic [ADDR_W-1:0] inst_pc_reg, inst_pc_next;
    logic [ADDR_W-1:0] redirect_target;
    logic              req_fire;

`ifdef FETCH_MISALIGN_EN
    logic fault_reg, fault_next;
    logic pc_misaligned;

    assign pc_misaligned   = (pc_reg[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
    // A misaligned PC never reaches memory; it is reported to decode instead.
    assign imem_req_valid  = (state_reg == REQ) && !pc_misaligned;
    assign inst_fault      = fault_reg;
`else
    logic redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign imem_req_valid      = (state_reg == REQ);
    assign inst_fault          = 1'b0;
`endif

    assign imem_req_addr = pc_reg;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign inst_valid    = inst_valid_reg;
    assign inst_data     = inst_data_reg;
    assign inst_pc       = inst_pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            inst_valid_reg <= 1'b0;
            inst_data_reg  <= '0;
            inst_pc_reg    <= '0;
`ifdef FETCH_MISALIGN_EN
            fault_reg      <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_valid_reg <= inst_valid_next;
            inst_data_reg  <= inst_data_next;
            inst_pc_reg    <= inst_pc_next;
`ifdef FETCH_MISALIGN_EN
            fault_reg      <= fault_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_valid_next = inst_valid_reg;
        inst_data_next  = inst_data_reg;
        inst_pc_next    = inst_pc_reg;
`ifdef FETCH_MISALIGN_EN
        fault_next      = fault_reg;
`endif

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
`ifdef FETCH_MISALIGN_EN
                if (pc_misaligned) begin
                    state_next      = HOLD;
                    inst_valid_next = 1'b1;
                    inst_data_next  = '0;
                    inst_pc_next    = pc_reg;
                    fault_next      = 1'b1;
                end else
`endif
                if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_next      = HOLD;
                    inst_valid_next = 1'b1;
                    inst_data_next  = imem_rsp_data;
                    inst_pc_next    = pc_reg;
                    pc_next         = pc_reg + ADDR_W'(PC_STEP);
                end
            end
            HOLD: begin
                // With inst_valid low, HOLD is a stall that only a redirect can leave.
                if (inst_valid_reg && inst_ready) begin
                    inst_valid_next = 1'b0;
                    state_next      = REQ;
`ifdef FETCH_MISALIGN_EN
                    if (fault_reg) begin
                        state_next = HOLD;
                    end
`endif
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Redirect wins over everything decided above; pending or arriving words are squashed.
        if (redirect_valid) begin
            pc_next         = redirect_target;
            inst_valid_next = 1'b0;
            inst_data_next  = inst_data_reg;
            inst_pc_next    = inst_pc_reg;
`ifdef FETCH_MISALIGN_EN
            fault_next      = 1'b0;
`endif
            case (state_reg)
                IDLE:    state_next = REQ;
                REQ:     state_next = req_fire ? DROP : REQ;
                WAIT:    state_next = imem_rsp_valid ? REQ : DROP;
                HOLD:    state_next = REQ;
                DROP:    state_next = imem_rsp_valid ? REQ : DROP;
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: memory model + transaction-level fetch model drive expectations,
// an independent monitor pops and compares every instruction handed to decode.
`timescale 1ns/1ps
module tb_pc_fetch;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam logic [31:0] RESET_PC = 32'd0;
    localparam int          PC_STEP  = 4;

    logic              clk;
    logic              rst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_fault;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } inst_t;

    inst_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;

    // memory model and architectural fetch model
    bit          mem_busy = 0;
    bit          mem_stale = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          mem_lat_min = 1;
    int          mem_lat_max = 1;
    logic [31:0] model_pc = RESET_PC;

    bit          last_acc;
    bit          last_hs;
    logic [31:0] last_acc_addr;

    pc_fetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic inst_t mk(input logic [31:0] pc, input logic [31:0] data, input logic fault);
        inst_t e;
        e.pc    = pc;
        e.data  = data;
        e.fault = fault;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One clock of stimulus; inputs are set mid-cycle and the coming edge's events fed to the model.
    task automatic step(input bit req_rdy, input bit ins_rdy, input bit redir, input logic [31:0] target);
        bit acc;
        bit rsp;
        @(negedge clk);
        cycle++;
        rsp            = mem_busy && (mem_cnt == 0);
        imem_rsp_valid = rsp;
        imem_rsp_data  = (rsp && mem_addr == 32'h4) ? 32'hDEADBEEF : $urandom;
        imem_req_ready = req_rdy;
        inst_ready     = ins_rdy;
        redirect_valid = redir;
        redirect_pc    = target;
        #1;
        acc           = imem_req_valid && imem_req_ready;
        last_acc      = acc;
        last_acc_addr = imem_req_addr;
        last_hs       = inst_valid && inst_ready && !redirect_valid;
`ifdef FETCH_MISALIGN_EN
        if (model_pc[1:0] != 2'b00) check("req_while_fault_stall", {63'd0, imem_req_valid}, 64'd0);
`endif
        if (acc) begin
            check("req_addr", {32'd0, imem_req_addr}, {32'd0, model_pc});
            check("single_outstanding", {63'd0, mem_busy && !rsp}, 64'd0);
        end
        if (mem_busy) begin
            if (rsp) begin
                mem_busy = 0;
                if (!mem_stale && !redir) begin
                    exp_q.push_back(mk(mem_addr, imem_rsp_data, 1'b0));
                    model_pc = mem_addr + 32'(PC_STEP);
                end
            end else begin
                mem_cnt--;
            end
        end
        if (acc) begin
            mem_busy  = 1;
            mem_stale = redir;
            mem_addr  = imem_req_addr;
            mem_cnt   = $urandom_range(mem_lat_max, mem_lat_min) - 1;
        end
        if (redir) begin
            exp_q.delete();
            if (mem_busy) mem_stale = 1;
`ifdef FETCH_MISALIGN_EN
            model_pc = target;
            if (target[1:0] != 2'b00) exp_q.push_back(mk(target, 32'd0, 1'b1));
`else
            model_pc = {target[31:2], 2'b00};
`endif
        end
    endtask

    task automatic do_reset(input bit check_vals);
        @(posedge clk);
        #3;
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        #1;
        if (check_vals) begin
            check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
            check("rst_req_addr", {32'd0, imem_req_addr}, {32'd0, RESET_PC});
            check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
            check("rst_inst_data", {32'd0, inst_data}, 64'd0);
            check("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
            check("rst_inst_fault", {63'd0, inst_fault}, 64'd0);
        end
        exp_q.delete();
        mem_busy  = 0;
        mem_stale = 0;
        model_pc  = RESET_PC;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_acc(input string name, input logic [31:0] want);
        int n;
        for (n = 0; n < 40; n++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (last_acc) break;
        end
        check({name, "_timeout"}, {63'd0, n < 40}, 64'd1);
        check(name, {32'd0, last_acc_addr}, {32'd0, want});
    endtask

    // Monitor: every decode handshake not squashed by a redirect must match the scoreboard head.
    initial begin
        inst_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && inst_valid && inst_ready && !redirect_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL inst_unexpected: got pc=%h data=%h fault=%b, required no delivery",
                             inst_pc, inst_data, inst_fault);
                end else begin
                    e = exp_q.pop_front();
                    if (inst_pc !== e.pc || inst_data !== e.data || inst_fault !== e.fault) begin
                        errors++;
                        $display("FAIL inst_match: got pc=%h data=%h fault=%b required pc=%h data=%h fault=%b",
                                 inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
                    end else begin
                        $display("inst pc=%h data=%h fault=%b", inst_pc, inst_data, inst_fault);
                    end
                end
            end
        end
    end

    initial begin
        int          hs_cyc[$];
        logic [31:0] acc_log[$];
        int          n;
        logic [31:0] tgt;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;

        // reset values and first-request timing
        do_reset(1'b1);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("req_valid_before_2nd_edge", {63'd0, imem_req_valid}, 64'd0);

        // zero-wait stream: 0x0, 0x4, 0x8 at one instruction per 3 cycles
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (i == 0) check("req_valid_after_2nd_edge", {63'd0, imem_req_valid}, 64'd1);
            if (last_hs) hs_cyc.push_back(cycle);
            if (last_acc) acc_log.push_back(last_acc_addr);
        end
        check("stream_hs_count", {63'd0, hs_cyc.size() >= 4}, 64'd1);
        check("stream_acc_count", {63'd0, acc_log.size() >= 3}, 64'd1);
        for (int i = 0; i < 3 && i + 1 < hs_cyc.size(); i++)
            check("throughput_gap", 64'(hs_cyc[i+1] - hs_cyc[i]), 64'd3);
        for (int i = 0; i < 3 && i < acc_log.size(); i++)
            check("stream_addr", {32'd0, acc_log[i]}, 64'(i * 4));

        // decode backpressure on word 0xDEADBEEF at pc 0x4
        do_reset(1'b0);
        for (n = 0; n < 40; n++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (last_hs) break;
        end
        check("first_hs_timeout", {63'd0, n < 40}, 64'd1);
        for (n = 0; n < 40; n++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (inst_valid) break;
        end
        check("hold_valid_timeout", {63'd0, n < 40}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            check("hold_valid", {63'd0, inst_valid}, 64'd1);
            check("hold_data", {32'd0, inst_data}, 64'hDEADBEEF);
            check("hold_pc", {32'd0, inst_pc}, 64'h4);
            check("hold_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        step(1'b1, 1'b1, 1'b0, 32'd0);

        // redirect while waiting; stale response lands two cycles later
        mem_lat_min = 3;
        mem_lat_max = 3;
        for (n = 0; n < 40; n++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (last_acc) break;
        end
        check("wait_acc_timeout", {63'd0, n < 40}, 64'd1);
        step(1'b1, 1'b1, 1'b1, 32'h100);
        wait_acc("redirect_wait_addr", 32'h100);

        // redirect coinciding with the response
        mem_lat_min = 2;
        mem_lat_max = 2;
        for (n = 0; n < 40; n++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (mem_busy && mem_cnt == 0 && !mem_stale) break;
        end
        check("rsp_due_timeout", {63'd0, n < 40}, 64'd1);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        wait_acc("redirect_rsp_addr", 32'h200);

        // redirect in HOLD with decode ready in the same cycle
        mem_lat_min = 1;
        mem_lat_max = 1;
        for (n = 0; n < 40; n++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (inst_valid) break;
        end
        check("hold2_timeout", {63'd0, n < 40}, 64'd1);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        wait_acc("redirect_hold_addr", 32'h200);

        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 1'b1, 32'hFFFFFFFC);
        wait_acc("wrap_addr_top", 32'hFFFFFFFC);
        wait_acc("wrap_addr_zero", 32'h00000000);

        // misaligned redirect target
        step(1'b1, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_EN
        for (n = 0; n < 40; n++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (inst_valid) break;
        end
        check("fault_timeout", {63'd0, n < 40}, 64'd1);
        check("fault_flag", {63'd0, inst_fault}, 64'd1);
        check("fault_pc", {32'd0, inst_pc}, 64'h102);
        check("fault_data", {32'd0, inst_data}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            check("fault_stall_valid", {63'd0, inst_valid}, 64'd0);
        end
        step(1'b1, 1'b1, 1'b1, 32'h104);
        wait_acc("fault_resume_addr", 32'h104);
`else
        wait_acc("misalign_forced_addr", 32'h100);
`endif

        // randomized traffic with one asynchronous reset mid-run
        mem_lat_min = 1;
        mem_lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(1'b1);
            tgt = $urandom_range(0, 3) == 0 ? {20'hFFFFF, 12'($urandom)} : {20'h00000, 12'($urandom)};
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, tgt);
        end

        // drain: no new requests, decode always ready
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
